// File: rtl/mem_block_ctrl.sv
// Lower-level memory stage behind the cache controller: serves 4-word block
// write-backs and refills from a word-wide backing SRAM, with a preload port.
module mem_block_ctrl #(
    parameter int ADDR_WIDTH     = 28,
    parameter int WORD_WIDTH     = 32,
    parameter int MEM_DEPTH_LOG2 = 10,
    parameter int ACCESS_LAT     = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      Req_Low,
    input  logic                      Wr_Low,
    input  logic [ADDR_WIDTH-1:0]     A_Low,
    input  logic [4*WORD_WIDTH-1:0]   D_Low_In,
    output logic [4*WORD_WIDTH-1:0]   D_Low_Out,
    output logic                      Rdy_Low,
    output logic                      Busy,
    input  logic                      Init_En,
    input  logic [MEM_DEPTH_LOG2-1:0] Init_Addr,
    input  logic [WORD_WIDTH-1:0]     Init_Data
);

    localparam int         DEPTH = 1 << MEM_DEPTH_LOG2;
    localparam int         BLK_W = MEM_DEPTH_LOG2 - 2;
    localparam logic [3:0] LAT_C = 4'(ACCESS_LAT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t                    state_r;
    state_t                    state_s;
    logic [3:0]                wait_r;
    logic [1:0]                beat_r;
    logic                      wr_r;
    logic [BLK_W-1:0]          blk_r;
    logic [4*WORD_WIDTH-1:0]   wdata_r;
    logic [3*WORD_WIDTH-1:0]   rbuf_r;
    logic [4*WORD_WIDTH-1:0]   dout_r;
    logic                      rdy_r;
    logic                      busy_r;

    logic [WORD_WIDTH-1:0]     mem [DEPTH];

    logic                      xfer_s;
    logic [MEM_DEPTH_LOG2-1:0] word_addr_s;
    logic [WORD_WIDTH-1:0]     rd_word_s;
    logic [WORD_WIDTH-1:0]     wr_word_s;
    logic                      mem_we_s;
    logic [MEM_DEPTH_LOG2-1:0] mem_waddr_s;
    logic [WORD_WIDTH-1:0]     mem_wdata_s;
    logic                      addr_unused_s;

    // Upper block-address bits alias away: only the SRAM-sized slice is kept.
    assign addr_unused_s = ^A_Low[ADDR_WIDTH-1:BLK_W];

    // Current beat address, read word and write word selection.
    always_comb begin
        xfer_s      = (state_r == ST_ACCESS) && (wait_r == 4'd0);
        word_addr_s = {blk_r, beat_r};
        rd_word_s   = mem[word_addr_s];
        case (beat_r)
            2'd0:    wr_word_s = wdata_r[WORD_WIDTH-1:0];
            2'd1:    wr_word_s = wdata_r[2*WORD_WIDTH-1:WORD_WIDTH];
            2'd2:    wr_word_s = wdata_r[3*WORD_WIDTH-1:2*WORD_WIDTH];
            default: wr_word_s = wdata_r[4*WORD_WIDTH-1:3*WORD_WIDTH];
        endcase
    end

    // SRAM write port arbitration: a pending request blocks the preload.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = word_addr_s;
        mem_wdata_s = wr_word_s;
        if (rst) begin
            mem_we_s = 1'b0;
        end else if ((state_r == ST_IDLE) && !Req_Low && Init_En) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = Init_Addr;
            mem_wdata_s = Init_Data;
        end else if (xfer_s && wr_r) begin
            mem_we_s = 1'b1;
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (Req_Low) state_s = ST_ACCESS;
                else         state_s = ST_IDLE;
            end
            ST_ACCESS: begin
                if (xfer_s && (beat_r == 2'd3)) state_s = ST_DONE;
                else                            state_s = ST_ACCESS;
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Backing SRAM; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) mem[mem_waddr_s] <= mem_wdata_s;
    end

    // State register, request latches, beat sequencing and refill assembly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            wait_r  <= 4'd0;
            beat_r  <= 2'd0;
            wr_r    <= 1'b0;
            blk_r   <= '0;
            wdata_r <= '0;
            rbuf_r  <= '0;
            dout_r  <= '0;
            rdy_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != ST_IDLE);
            rdy_r   <= (state_r == ST_DONE);
            case (state_r)
                ST_IDLE: begin
                    if (Req_Low) begin
                        wr_r    <= Wr_Low;
                        blk_r   <= A_Low[BLK_W-1:0];
                        wdata_r <= D_Low_In;
                        beat_r  <= 2'd0;
                        wait_r  <= LAT_C;
                    end
                end
                ST_ACCESS: begin
                    if (wait_r != 4'd0) begin
                        wait_r <= wait_r - 4'd1;
                    end else begin
                        if (!wr_r) begin
                            case (beat_r)
                                2'd0:    rbuf_r[WORD_WIDTH-1:0]              <= rd_word_s;
                                2'd1:    rbuf_r[2*WORD_WIDTH-1:WORD_WIDTH]   <= rd_word_s;
                                2'd2:    rbuf_r[3*WORD_WIDTH-1:2*WORD_WIDTH] <= rd_word_s;
                                default: dout_r <= {rd_word_s, rbuf_r};
                            endcase
                        end
                        if (beat_r != 2'd3) begin
                            beat_r <= beat_r + 2'd1;
                            wait_r <= LAT_C;
                        end
                    end
                end
                ST_DONE: begin
                    beat_r <= 2'd0;
                end
                default: begin
                    beat_r <= 2'd0;
                end
            endcase
        end
    end

    assign D_Low_Out = dout_r;
    assign Rdy_Low   = rdy_r;
    assign Busy      = busy_r;

endmodule
